pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It generalises the fixed-field stage registers between IF/ID/EX/MEM/WB into one reusable block. Stall is handled by backpressure instead of a shared write enable, and flush inserts a bubble without losing accepted data ordering. A bubble carries an all-zero control field, so downstream stages see a NOP (no RegWrite, MemWrite, MemRead or branch).

## Interface
Parameters:
- DATA_W, 64, width of the datapath payload (ALU result, store data, branch target, concatenated by the instantiating stage)
- CTRL_W, 9, width of the control payload (flags plus control bits); forced to zero in any invalid entry
- Constraint: DATA_W ≥ 1, CTRL_W ≥ 1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream offers a beat
- in_ready  out  1  block can accept a beat this cycle
- in_ctrl  in  CTRL_W  control payload
- in_data  in  DATA_W  data payload
- out_valid  out  1  beat available to downstream
- out_ready  in  1  downstream accepts the beat this cycle
- out_ctrl  out  CTRL_W  control payload of the head entry; 0 when out_valid=0
- out_data  out  DATA_W  data payload of the head entry
- flush  in  1  discard all held beats (branch mispredict, exception)
- occupancy  out  2  number of valid entries (0..2)

## Operation
- Storage: a head entry (drives outputs) and a skid entry, each holding {valid, ctrl, data}.
- State machine on occupancy:
  - EMPTY: accept moves to ONE.
  - ONE: accept without pop stays and fills the skid entry, moving to TWO. Accept with pop stays ONE, and the new beat goes to head. Pop without accept moves to EMPTY.
  - TWO: pop moves skid to head and goes to ONE. No accept is possible.
- accept = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (occupancy != 2) & reset. It is registered-equivalent: it depends only on state, never combinationally on out_ready.
- Ordering is strict FIFO. The skid entry is always older than any newly accepted beat.
- Flush (synchronous, highest priority):
  - Next state is EMPTY, and both valid bits clear.
  - Both ctrl fields are cleared to 0. Data fields may retain stale values.
  - A beat offered in the flush cycle is dropped, even if in_valid=1 and in_ready=1.
  - A pop in the same cycle as flush still counts as delivered, because downstream sampled it.
- Any entry written invalid has its ctrl forced to 0. Therefore out_ctrl == 0 whenever out_valid == 0.
- Payload is captured unmodified. No width conversion takes place.

## Timing
- Reset asserted (reset=0): out_valid=0, out_ctrl=0, occupancy=0, in_ready=0 immediately (asynchronous). out_data is 0.
- First cycle after reset deasserts: in_ready=1.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle while out_ready=1 continuously. Occupancy stays ≤1 in that case.
- Backpressure: after out_ready drops, at most one further beat is accepted into skid. Then in_ready=0 until a pop.
- Flush asserted in cycle N: out_valid=0 and occupancy=0 from cycle N+1. in_ready=1 in N+1.
- Reset asserted mid-transfer: all state clears asynchronously. No partial beat is ever presented.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Test plan
- Reset and streaming:
  - Stimulus: reset=0 for 3 cycles, then release; push data 0x1..0x8 with ctrl 0x1FF, out_ready=1.
  - Required response: all outputs 0 during reset; outputs 0x1..0x8 in order, one per cycle, with 1-cycle latency; occupancy never exceeds 1.
- Backpressure:
  - Stimulus: out_ready=0 while pushing 0xA, 0xB, 0xC.
  - Required response: 0xA in head and 0xB in skid; in_ready=0 with 0xC held upstream. After out_ready=1, outputs are 0xA, 0xB, 0xC in order with none lost or duplicated.
- Flush when full:
  - Stimulus: occupancy=2 holding 0x11 and 0x22; pulse flush together with in_valid=1 carrying 0x33.
  - Required response: next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x33 is dropped; the next pushed beat 0x44 emerges first.
- Simultaneous accept and pop:
  - Stimulus: occupancy=1; in_valid=1 and out_ready=1 in the same cycle for 10 cycles.
  - Required response: occupancy stays 1 and the payload sequence is preserved.
- Asynchronous reset mid-stream:
  - Stimulus: drop reset between clock edges with occupancy=2.
  - Required response: out_valid, occupancy and in_ready go to 0 before the next edge; after release, the first beat out is the first beat pushed post-reset.
- Parameter sweep:
  - Stimulus: DATA_W=1 with CTRL_W=1, and DATA_W=128 with CTRL_W=16; run a random valid/ready stimulus against a reference FIFO.
  - Required response: bit-exact order match; out_ctrl==0 whenever out_valid==0.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying a control and a data payload.
// The producer side uses master, the consumer side uses slave.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 9
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output ctrl,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  ctrl,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: head plus skid entry behind a
// valid/ready handshake, with synchronous flush that inserts a bubble.
module pipe_stage_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 9
) (
   input  logic             clk,
   input  logic             reset,
   pipe_stage_reg_if.slave  in_bus,
   pipe_stage_reg_if.master out_bus,
   input  logic             flush,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
   logic [DATA_W-1:0] head_data, skid_data;

   logic head_vld;
   logic in_ready;
   logic accept;
   logic pop;
   logic head_in, head_skid, head_clr;
   logic skid_in, skid_clr;

   // in_ready looks only at state, so out_ready never reaches it
   assign in_ready = (state != TWO) & reset;
   assign head_vld = (state != EMPTY);
   assign accept   = in_bus.valid & in_ready;
   assign pop      = head_vld & out_bus.ready;

   always_comb begin
      state_n   = state;
      head_in   = 1'b0;
      head_skid = 1'b0;
      head_clr  = 1'b0;
      skid_in   = 1'b0;
      skid_clr  = 1'b0;
      if (flush) begin
         state_n  = EMPTY;
         head_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state_n = ONE;
                  head_in = 1'b1;
               end
            end
            ONE: begin
               unique case (1'b1)
                  accept & ~pop: begin
                     state_n = TWO;
                     skid_in = 1'b1;
                  end
                  accept & pop: begin
                     head_in = 1'b1;
                  end
                  ~accept & pop: begin
                     state_n  = EMPTY;
                     head_clr = 1'b1;
                  end
                  default: ;
               endcase
            end
            TWO: begin
               if (pop) begin
                  state_n   = ONE;
                  head_skid = 1'b1;
                  skid_clr  = 1'b1;
               end
            end
            default: begin
               state_n  = EMPTY;
               head_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= state_n;
      end
   end

   // Vacated entries get ctrl zeroed so a bubble always reads as a NOP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_ctrl <= '0;
         head_data <= '0;
      end else if (head_clr) begin
         head_ctrl <= '0;
      end else if (head_in) begin
         head_ctrl <= in_bus.ctrl;
         head_data <= in_bus.data;
      end else if (head_skid) begin
         head_ctrl <= skid_ctrl;
         head_data <= skid_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (skid_clr) begin
         skid_ctrl <= '0;
      end else if (skid_in) begin
         skid_ctrl <= in_bus.ctrl;
         skid_data <= in_bus.data;
      end
   end

   assign in_bus.ready  = in_ready;
   assign out_bus.valid = head_vld;
   assign out_bus.ctrl  = head_ctrl;
   assign out_bus.data  = head_data;
   assign occupancy     = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg plus a seeded random sweep
// of two extra widths against a reference queue.
module tb_pipe_stage_reg;

   logic clk;
   logic reset;
   logic flush0, flush1, flush2;
   logic [1:0] occ0, occ1, occ2;

   int checks;
   int errors;

   pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(9)) a_in ();
   pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(9)) a_out ();
   pipe_stage_reg_if #(.DATA_W(1), .CTRL_W(1)) b_in ();
   pipe_stage_reg_if #(.DATA_W(1), .CTRL_W(1)) b_out ();
   pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(16)) c_in ();
   pipe_stage_reg_if #(.DATA_W(128), .CTRL_W(16)) c_out ();

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(9)) dut0 (
      .clk(clk), .reset(reset),
      .in_bus(a_in), .out_bus(a_out),
      .flush(flush0), .occupancy(occ0)
   );

   pipe_stage_reg #(.DATA_W(1), .CTRL_W(1)) dut1 (
      .clk(clk), .reset(reset),
      .in_bus(b_in), .out_bus(b_out),
      .flush(flush1), .occupancy(occ1)
   );

   pipe_stage_reg #(.DATA_W(128), .CTRL_W(16)) dut2 (
      .clk(clk), .reset(reset),
      .in_bus(c_in), .out_bus(c_out),
      .flush(flush2), .occupancy(occ2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic head(input string tag, input logic v,
                       input logic [63:0] d, input logic [1:0] o);
      check({tag, ".valid"}, 128'(a_out.valid), 128'(v));
      check({tag, ".occ"}, 128'(occ0), 128'(o));
      if (v) begin
         check({tag, ".data"}, 128'(a_out.data), 128'(d));
         check({tag, ".ctrl"}, 128'(a_out.ctrl), 128'h1ff);
      end else begin
         check({tag, ".ctrl0"}, 128'(a_out.ctrl), 128'h0);
      end
   endtask

   task automatic push(input logic [63:0] d);
      a_in.valid = 1'b1;
      a_in.data  = d;
      a_in.ctrl  = 9'h1ff;
   endtask

   logic [1:0]   qb[$];
   logic [143:0] qc[$];
   logic         acc, pp;

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      flush0 = 1'b0;
      flush1 = 1'b0;
      flush2 = 1'b0;
      a_in.valid = 1'b0; a_in.ctrl = '0; a_in.data = '0;
      b_in.valid = 1'b0; b_in.ctrl = '0; b_in.data = '0;
      c_in.valid = 1'b0; c_in.ctrl = '0; c_in.data = '0;
      a_out.ready = 1'b0;
      b_out.ready = 1'b0;
      c_out.ready = 1'b0;

      repeat (3) @(negedge clk);
      head("rst", 1'b0, '0, 2'd0);
      check("rst.in_ready", 128'(a_in.ready), 128'h0);
      check("rst.data", 128'(a_out.data), 128'h0);
      reset = 1'b1;
      #1;
      check("rel.in_ready", 128'(a_in.ready), 128'h1);

      // streaming 1..8 with out_ready held high
      a_out.ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(64'(i));
         @(negedge clk);
         head($sformatf("stream%0d", i), 1'b1, 64'(i), 2'd1);
      end
      a_in.valid = 1'b0;
      @(negedge clk);
      head("stream.end", 1'b0, '0, 2'd0);

      // backpressure: A head, B skid, C held off
      a_out.ready = 1'b0;
      push(64'hA);
      @(negedge clk);
      head("bp.a", 1'b1, 64'hA, 2'd1);
      push(64'hB);
      @(negedge clk);
      head("bp.ab", 1'b1, 64'hA, 2'd2);
      check("bp.rdy0", 128'(a_in.ready), 128'h0);
      push(64'hC);
      @(negedge clk);
      head("bp.hold", 1'b1, 64'hA, 2'd2);
      check("bp.rdy0b", 128'(a_in.ready), 128'h0);
      a_out.ready = 1'b1;
      @(negedge clk);
      head("bp.b", 1'b1, 64'hB, 2'd1);
      check("bp.rdy1", 128'(a_in.ready), 128'h1);
      @(negedge clk);
      head("bp.c", 1'b1, 64'hC, 2'd1);
      a_in.valid = 1'b0;
      @(negedge clk);
      head("bp.end", 1'b0, '0, 2'd0);

      // flush while full, with a beat offered in the flush cycle
      a_out.ready = 1'b0;
      push(64'h11);
      @(negedge clk);
      push(64'h22);
      @(negedge clk);
      head("fl.full", 1'b1, 64'h11, 2'd2);
      push(64'h33);
      flush0 = 1'b1;
      @(negedge clk);
      flush0 = 1'b0;
      a_in.valid = 1'b0;
      head("fl.bubble", 1'b0, '0, 2'd0);
      check("fl.rdy", 128'(a_in.ready), 128'h1);
      a_out.ready = 1'b1;
      push(64'h44);
      @(negedge clk);
      head("fl.44", 1'b1, 64'h44, 2'd1);
      a_in.valid = 1'b0;
      @(negedge clk);
      head("fl.end", 1'b0, '0, 2'd0);

      // simultaneous accept and pop at occupancy 1
      a_out.ready = 1'b0;
      push(64'h100);
      @(negedge clk);
      head("ap.seed", 1'b1, 64'h100, 2'd1);
      a_out.ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         push(64'h100 + 64'(k));
         @(negedge clk);
         head($sformatf("ap%0d", k), 1'b1, 64'h100 + 64'(k), 2'd1);
      end
      a_in.valid = 1'b0;
      @(negedge clk);
      head("ap.end", 1'b0, '0, 2'd0);

      // asynchronous reset between edges with two beats held
      a_out.ready = 1'b0;
      push(64'h51);
      @(negedge clk);
      push(64'h52);
      @(negedge clk);
      a_in.valid = 1'b0;
      head("ar.full", 1'b1, 64'h51, 2'd2);
      #2;
      reset = 1'b0;
      #1;
      head("ar.async", 1'b0, '0, 2'd0);
      check("ar.rdy", 128'(a_in.ready), 128'h0);
      @(negedge clk);
      reset = 1'b1;
      a_out.ready = 1'b1;
      push(64'h61);
      @(negedge clk);
      head("ar.61", 1'b1, 64'h61, 2'd1);
      a_in.valid = 1'b0;
      @(negedge clk);
      head("ar.end", 1'b0, '0, 2'd0);

      // random sweep of the narrow and wide instances
      for (int n = 0; n < 300; n++) begin
         check("b.occ", 128'(occ1), 128'(qb.size()));
         check("b.rdy", 128'(b_in.ready), 128'(qb.size() != 2));
         check("b.valid", 128'(b_out.valid), 128'(qb.size() != 0));
         if (qb.size() != 0)
            check("b.beat", 128'({b_out.ctrl, b_out.data}), 128'(qb[0]));
         else
            check("b.ctrl0", 128'(b_out.ctrl), 128'h0);

         check("c.occ", 128'(occ2), 128'(qc.size()));
         check("c.valid", 128'(c_out.valid), 128'(qc.size() != 0));
         if (qc.size() != 0) begin
            check("c.data", c_out.data, qc[0][127:0]);
            check("c.ctrl", 128'(c_out.ctrl), 128'(qc[0][143:128]));
         end else begin
            check("c.ctrl0", 128'(c_out.ctrl), 128'h0);
         end

         b_in.valid  = 1'($urandom_range(0, 1));
         b_in.ctrl   = 1'($urandom_range(0, 1));
         b_in.data   = 1'($urandom_range(0, 1));
         b_out.ready = 1'($urandom_range(0, 1));
         flush1      = ($urandom_range(0, 19) == 0);
         acc = b_in.valid && (qb.size() != 2);
         pp  = b_out.ready && (qb.size() != 0);
         if (flush1) begin
            qb.delete();
         end else begin
            if (pp) void'(qb.pop_front());
            if (acc) qb.push_back({b_in.ctrl, b_in.data});
         end

         c_in.valid  = 1'($urandom_range(0, 1));
         c_in.ctrl   = 16'($urandom);
         c_in.data   = {$urandom, $urandom, $urandom, $urandom};
         c_out.ready = 1'($urandom_range(0, 1));
         flush2      = ($urandom_range(0, 19) == 0);
         acc = c_in.valid && (qc.size() != 2);
         pp  = c_out.ready && (qc.size() != 0);
         if (flush2) begin
            qc.delete();
         end else begin
            if (pp) void'(qc.pop_front());
            if (acc) qc.push_back({c_in.ctrl, c_in.data});
         end

         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
